// File: rtl/mem_xfer_pkg.sv
// Shared definitions for the memory-to-memory transfer controller:
// state encoding, default sizing and helpers that derive depth from N.
package mem_xfer_pkg;

  // Default address MSB index and data width
  localparam int DEF_N = 2;
  localparam int DEF_W = 8;

  // Number of locations covered by an (n+1)-bit address counter
  function automatic int xfer_depth(input int n);
    return 1 << (n + 1);
  endfunction

  // Highest address reached by an (n+1)-bit address counter
  function automatic int xfer_last(input int n);
    return xfer_depth(n) - 1;
  endfunction

  // Depth and last address for the default sizing
  localparam int DEPTH = xfer_depth(DEF_N);
  localparam int LAST  = xfer_last(DEF_N);

  // Controller states, one word costs READ -> LATCH -> WRITE
  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    READ,
    LATCH,
    WRITE,
    DONE
  } xfer_state_e;

endpackage

// File: rtl/mem_xfer_ctrl.sv
// Sequencer that copies every word of memory A into the same address of
// memory B. The address counters and both memories live outside; this
// block only drives their clear/increment controls and the write path.
module mem_xfer_ctrl
  import mem_xfer_pkg::*;
#(
  parameter int N = DEF_N,
  parameter int W = DEF_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N:0]   addr_a,
  input  logic [W-1:0] data_a,
  output logic         clr_a,
  output logic         inc_a,
  output logic         clr_b,
  output logic         inc_b,
  output logic         we_b,
  output logic [W-1:0] data_b,
  output logic         busy,
  output logic         done
);

  // Final address: the word written while addr_a sits here ends the copy
  localparam int         LastInt  = xfer_last(N);
  localparam logic [N:0] LastAddr = LastInt[N:0];

  xfer_state_e  state_q, state_d;
  logic [W-1:0] data_b_q;

  // State register; a low rst at any edge abandons the copy and parks in IDLE
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Write-data register, captures the memory A word only while it is valid
  always_ff @(posedge clk) begin
    if (!rst) begin
      data_b_q <= '0;
    end else if (state_q == LATCH) begin
      data_b_q <= data_a;
    end
  end

  // Next-state logic and Moore decode of every control output
  always_comb begin
    state_d = state_q;
    clr_a   = 1'b0;
    clr_b   = 1'b0;
    inc_a   = 1'b0;
    inc_b   = 1'b0;
    we_b    = 1'b0;
    busy    = 1'b1;
    done    = 1'b0;
    case (state_q)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          state_d = CLEAR;
        end
      end
      CLEAR: begin
        clr_a   = 1'b1;
        clr_b   = 1'b1;
        state_d = READ;
      end
      READ: begin
        state_d = LATCH;
      end
      LATCH: begin
        state_d = WRITE;
      end
      WRITE: begin
        we_b  = 1'b1;
        inc_a = 1'b1;
        inc_b = 1'b1;
        if (addr_a == LastAddr) begin
          state_d = DONE;
        end else begin
          state_d = READ;
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: begin
        busy    = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  assign data_b = data_b_q;

endmodule

// File: tb/tb_mem_xfer_ctrl.sv
// Bench for mem_xfer_ctrl: models the external counters and memories,
// drives transfers and compares control timing and copied data against
// cycle-number formulas derived from the transfer rules.
module tb_mem_xfer_ctrl;

  localparam int N      = 2;
  localparam int W      = 8;
  localparam int DEPTH  = 1 << (N + 1);
  localparam int PERIOD = 3 * DEPTH + 3;
  localparam int MAXC   = 128;

  typedef struct packed {
    logic clrA;
    logic clrB;
    logic incA;
    logic incB;
    logic we;
    logic busy;
    logic done;
  } ctl_t;

  logic         clk   = 1'b0;
  logic         rst   = 1'b0;
  logic         start = 1'b0;
  logic [N:0]   addrA = '0;
  logic [N:0]   addrB = '0;
  logic [W-1:0] dataA = '0;
  logic [W-1:0] dataB;
  logic         clrA, incA, clrB, incB, weB, busy, done;

  logic [W-1:0] memA [DEPTH];
  logic [W-1:0] memB [DEPTH];

  int errors = 0;
  int checks = 0;

  ctl_t         obsCtl      [MAXC];
  logic [W-1:0] obsData     [MAXC];
  bit           startSched  [MAXC];
  bit           rstLowSched [MAXC];

  mem_xfer_ctrl #(.N(N), .W(W)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .addr_a (addrA),
    .data_a (dataA),
    .clr_a  (clrA),
    .inc_a  (incA),
    .clr_b  (clrB),
    .inc_b  (incB),
    .we_b   (weB),
    .data_b (dataB),
    .busy   (busy),
    .done   (done)
  );

  always #5 clk = ~clk;

  // External hardware: synchronous-read memory A, memory B and both counters
  always @(posedge clk) begin
    dataA <= memA[addrA];
    if (weB) memB[addrB] <= dataB;
    if (clrA) addrA <= '0;
    else if (incA) addrA <= addrA + 1'b1;
    if (clrB) addrB <= '0;
    else if (incB) addrB <= addrB + 1'b1;
  end

  // Expected controls for cycle tt of a transfer (tt=0 is the start/IDLE cycle)
  function automatic ctl_t expCtl(input int tt);
    ctl_t c;
    logic wr;
    wr     = (tt >= 4) && (tt <= 3 * DEPTH + 1) && ((tt - 4) % 3 == 0);
    c.clrA = (tt == 1);
    c.clrB = (tt == 1);
    c.incA = wr;
    c.incB = wr;
    c.we   = wr;
    c.busy = (tt >= 1) && (tt <= 3 * DEPTH + 2);
    c.done = (tt == 3 * DEPTH + 2);
    return c;
  endfunction

  // Expected data_b from cycle 4 on: the most recently latched word of A
  function automatic logic [W-1:0] expData(input int tt);
    int k;
    k = (tt - 4) / 3;
    if (k > DEPTH - 1) k = DEPTH - 1;
    return memA[k];
  endfunction

  task automatic clear_sched();
    for (int i = 0; i < MAXC; i++) begin
      startSched[i]  = 1'b0;
      rstLowSched[i] = 1'b0;
    end
  endtask

  task automatic poison_b();
    for (int i = 0; i < DEPTH; i++) memB[i] = ~memA[i];
  endtask

  // Records outputs at each negedge for cycles 1..ncyc, then applies that cycle's inputs
  task automatic capture(input int ncyc);
    for (int t = 1; t <= ncyc; t++) begin
      @(negedge clk);
      obsCtl[t]  = {clrA, clrB, incA, incB, weB, busy, done};
      obsData[t] = dataB;
      start      = startSched[t];
      rst        = !rstLowSched[t];
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < DEPTH; i++) memA[i] = W'(i);
    rst   = 1'b0;
    start = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if ({clrA, clrB, incA, incB, weB, busy, done} !== 7'b0) begin
        errors++;
        $display("[TB] FAIL reset_ctl cyc=%0d got=%b want=0000000", i,
                 {clrA, clrB, incA, incB, weB, busy, done});
      end
      checks++;
      if (dataB !== '0) begin
        errors++;
        $display("[TB] FAIL reset_data cyc=%0d got=%h want=00", i, dataB);
      end
    end
    clear_sched();
    rst = 1'b1;
    capture(PERIOD);
    checks++;
    if (obsCtl[1] !== expCtl(1)) begin
      errors++;
      $display("[TB] FAIL reset_release_clear got=%b want=%b", obsCtl[1], expCtl(1));
    end
    checks++;
    if (obsCtl[PERIOD - 1] !== expCtl(PERIOD - 1)) begin
      errors++;
      $display("[TB] FAIL reset_release_done got=%b want=%b",
               obsCtl[PERIOD - 1], expCtl(PERIOD - 1));
    end
  endtask

  task automatic test_full_copy();
    int weCount;
    for (int i = 0; i < DEPTH; i++) memA[i] = W'(3 * i + 1);
    poison_b();
    clear_sched();
    @(negedge clk);
    start = 1'b1;
    capture(PERIOD);
    weCount = 0;
    for (int t = 1; t <= PERIOD; t++) begin
      if (obsCtl[t].we) weCount++;
      checks++;
      if (obsCtl[t] !== expCtl(t)) begin
        errors++;
        $display("[TB] FAIL full_ctl t=%0d got=%b want=%b", t, obsCtl[t], expCtl(t));
      end
      if (t >= 4) begin
        checks++;
        if (obsData[t] !== expData(t)) begin
          errors++;
          $display("[TB] FAIL full_data t=%0d got=%h want=%h", t, obsData[t], expData(t));
        end
      end
    end
    checks++;
    if (weCount != DEPTH) begin
      errors++;
      $display("[TB] FAIL full_we_count got=%0d want=%0d", weCount, DEPTH);
    end
    for (int i = 0; i < DEPTH; i++) begin
      checks++;
      if (memB[i] !== W'(3 * i + 1)) begin
        errors++;
        $display("[TB] FAIL full_memb addr=%0d got=%h want=%h", i, memB[i], W'(3 * i + 1));
      end
    end
    checks++;
    if (addrA !== '0 || addrB !== '0) begin
      errors++;
      $display("[TB] FAIL full_counters got a=%0d b=%0d want 0 0", addrA, addrB);
    end
  endtask

  task automatic test_back_to_back();
    int weCount;
    int tt;
    logic [W-1:0] want;
    for (int i = 0; i < DEPTH; i++) memA[i] = W'($urandom);
    poison_b();
    clear_sched();
    for (int t = 1; t <= PERIOD; t++) startSched[t] = 1'b1;
    @(negedge clk);
    start = 1'b1;
    capture(2 * PERIOD);
    weCount = 0;
    for (int t = 1; t <= 2 * PERIOD; t++) begin
      tt = t % PERIOD;
      if (obsCtl[t].we) weCount++;
      checks++;
      if (obsCtl[t] !== expCtl(tt)) begin
        errors++;
        $display("[TB] FAIL b2b_ctl t=%0d got=%b want=%b", t, obsCtl[t], expCtl(tt));
      end
      if (tt >= 4 || t > PERIOD) begin
        want = (tt >= 4) ? expData(tt) : memA[DEPTH - 1];
        checks++;
        if (obsData[t] !== want) begin
          errors++;
          $display("[TB] FAIL b2b_data t=%0d got=%h want=%h", t, obsData[t], want);
        end
      end
    end
    checks++;
    if (weCount != 2 * DEPTH) begin
      errors++;
      $display("[TB] FAIL b2b_we_count got=%0d want=%0d", weCount, 2 * DEPTH);
    end
    for (int i = 0; i < DEPTH; i++) begin
      checks++;
      if (memB[i] !== memA[i]) begin
        errors++;
        $display("[TB] FAIL b2b_memb addr=%0d got=%h want=%h", i, memB[i], memA[i]);
      end
    end
  endtask

  task automatic test_ignored_start();
    int weCount;
    for (int i = 0; i < DEPTH; i++) memA[i] = W'($urandom);
    poison_b();
    clear_sched();
    startSched[5]  = 1'b1;
    startSched[20] = 1'b1;
    @(negedge clk);
    start = 1'b1;
    capture(PERIOD + 3);
    weCount = 0;
    for (int t = 1; t <= PERIOD + 3; t++) begin
      if (obsCtl[t].we) weCount++;
      checks++;
      if (obsCtl[t] !== expCtl(t)) begin
        errors++;
        $display("[TB] FAIL ign_ctl t=%0d got=%b want=%b", t, obsCtl[t], expCtl(t));
      end
      if (t >= 4) begin
        checks++;
        if (obsData[t] !== expData(t)) begin
          errors++;
          $display("[TB] FAIL ign_data t=%0d got=%h want=%h", t, obsData[t], expData(t));
        end
      end
    end
    checks++;
    if (weCount != DEPTH) begin
      errors++;
      $display("[TB] FAIL ign_we_count got=%0d want=%0d", weCount, DEPTH);
    end
    for (int i = 0; i < DEPTH; i++) begin
      checks++;
      if (memB[i] !== memA[i]) begin
        errors++;
        $display("[TB] FAIL ign_memb addr=%0d got=%h want=%h", i, memB[i], memA[i]);
      end
    end
  endtask

  task automatic test_mid_reset();
    int weCount;
    logic [W-1:0] want;
    for (int i = 0; i < DEPTH; i++) memA[i] = W'($urandom);
    poison_b();
    clear_sched();
    rstLowSched[10] = 1'b1;
    @(negedge clk);
    start = 1'b1;
    capture(30);
    weCount = 0;
    for (int t = 1; t <= 30; t++) begin
      if (obsCtl[t].we) weCount++;
      if (t <= 10) begin
        checks++;
        if (obsCtl[t] !== expCtl(t)) begin
          errors++;
          $display("[TB] FAIL midrst_ctl t=%0d got=%b want=%b", t, obsCtl[t], expCtl(t));
        end
      end else begin
        checks++;
        if (obsCtl[t] !== 7'b0 || obsData[t] !== '0) begin
          errors++;
          $display("[TB] FAIL midrst_idle t=%0d got ctl=%b data=%h want ctl=0000000 data=00",
                   t, obsCtl[t], obsData[t]);
        end
      end
    end
    checks++;
    if (weCount != 3) begin
      errors++;
      $display("[TB] FAIL midrst_we_count got=%0d want=3", weCount);
    end
    for (int i = 0; i < DEPTH; i++) begin
      want = (i < 3) ? memA[i] : ~memA[i];
      checks++;
      if (memB[i] !== want) begin
        errors++;
        $display("[TB] FAIL midrst_partial addr=%0d got=%h want=%h", i, memB[i], want);
      end
    end
    clear_sched();
    start = 1'b1;
    capture(PERIOD);
    for (int i = 0; i < DEPTH; i++) begin
      checks++;
      if (memB[i] !== memA[i]) begin
        errors++;
        $display("[TB] FAIL midrst_recopy addr=%0d got=%h want=%h", i, memB[i], memA[i]);
      end
    end
  endtask

  task automatic test_alternating();
    for (int i = 0; i < DEPTH; i++) memA[i] = (i % 2 == 0) ? 8'hFF : 8'h00;
    poison_b();
    clear_sched();
    @(negedge clk);
    start = 1'b1;
    capture(PERIOD);
    for (int t = 4; t <= PERIOD; t++) begin
      checks++;
      if (obsData[t] !== expData(t)) begin
        errors++;
        $display("[TB] FAIL alt_data t=%0d got=%h want=%h", t, obsData[t], expData(t));
      end
    end
    for (int i = 0; i < DEPTH; i++) begin
      checks++;
      if (memB[i] !== memA[i]) begin
        errors++;
        $display("[TB] FAIL alt_memb addr=%0d got=%h want=%h", i, memB[i], memA[i]);
      end
    end
  endtask

  // Scenario sequence
  initial begin
    test_reset();
    test_full_copy();
    test_back_to_back();
    test_ignored_start();
    test_mid_reset();
    test_alternating();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_xfer_ctrl.md
# mem_xfer_ctrl

Sequencing controller for the memory-to-memory transfer path. It sits directly upstream of address counter A and the destination counter B, and drives their increment and clear controls. It times the synchronous read of memory A, captures each word, and writes it into memory B. One start pulse copies every location of A (0 to LAST) into the same location of B, then reports done.

## Interface
- N, default 2: address MSB index. Counters are N+1 bits wide; DEPTH = 2^(N+1); LAST = DEPTH-1.
- W, default 8: data word width.

- clk  in  1  rising-edge clock
- rst  in  1  reset: synchronous and active-low; one clock; sampled only on clk rising edge
- start  in  1  transfer request, sampled only in IDLE
- addr_a  in  N+1  current value of address counter A
- data_a  in  W  memory A read data, valid one cycle after the address is sampled by the memory
- clr_a  out  1  clear for counter A (drives its active-high reset)
- inc_a  out  1  increment for counter A
- clr_b  out  1  clear for counter B
- inc_b  out  1  increment for counter B
- we_b  out  1  memory B write enable
- data_b  out  W  registered write data for memory B
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle completion pulse

## Operation
- States and transitions:
  - IDLE: go to CLEAR when start=1; otherwise stay.
  - CLEAR: clr_a=clr_b=1; go to READ.
  - READ: addr_a is stable and presented to memory A; go to LATCH.
  - LATCH: data_a is valid; data_b <= data_a at the end of the cycle; go to WRITE.
  - WRITE: we_b=inc_a=inc_b=1. Go to DONE if addr_a==LAST, else go to READ.
  - DONE: done=1; go to IDLE unconditionally.
- All control outputs are Moore outputs decoded from state. data_b is a register that loads only in LATCH and otherwise holds.
- The last WRITE still pulses inc_a and inc_b, so both counters wrap LAST→0. This is intended.
- start is ignored outside IDLE. start held high gives back-to-back transfers; IDLE still lasts one cycle between transfers.
- The LAST comparison uses the full N+1-bit addr_a. addr_a is not checked for consistency otherwise.
- rst=0 at any clock edge, including mid-transfer, forces IDLE and data_b=0 at that edge. The partial contents of B are left as written, and no further we_b occurs.

## Timing
- Reset values: state IDLE; clr_a, inc_a, clr_b, inc_b, we_b, busy, done = 0; data_b = 0.
- Cycle numbering: cycle 0 is the cycle in which start=1 is sampled in IDLE.
  - CLEAR is cycle 1.
  - Word k occupies READ at cycle 2+3k, LATCH at 3+3k, and WRITE at 4+3k.
  - DONE is at cycle 3·DEPTH+2, with IDLE the following cycle.
- Per-word throughput is 3 cycles. Total busy time is 3·DEPTH+2 cycles; for N=2 this is 26 cycles.
- busy rises in cycle 1 and falls after DONE. done and busy are both high during DONE.
- In WRITE, memory B samples the pre-increment addr_b. Counters A and B advance at the same edge.

## Structure
- Shared package mem_xfer_pkg holds:
  - the state enum: IDLE, CLEAR, READ, LATCH, WRITE, DONE;
  - localparams for DEPTH and LAST as functions of N;
  - the default W.
- Single module with no sub-module: one state register, one data_b register, and output decode. Counters and memories stay external.

## Test plan
- Reset: hold rst=0 for 2 cycles with start=1 → all outputs 0 and no CLEAR. Release → CLEAR appears in the cycle after the first edge that samples rst=1 with start=1.
- Full copy, N=2, W=8, memory A holds 3·addr+1:
  - start pulse at cycle 0 → clr_a/clr_b high in cycle 1;
  - we_b high in cycles 4, 7, …, 25 with data_b = 1, 4, …, 22 at B addresses 0..7;
  - done in cycle 26 only; counters read 0 afterwards.
- start held high continuously → second CLEAR in cycle 28; the second copy is identical to the first.
- start pulsed in cycles 5 and 20 during busy → ignored; exactly 8 we_b pulses; timing unchanged.
- rst=0 at cycle 10 (mid-transfer) → all outputs 0 from cycle 11 and no further we_b. A fresh start then copies all 8 words correctly.
- Memory A holds 0xFF and 0x00 alternating → B matches bit-exactly, confirming data_b holds between LATCH loads.
